// File: rtl/sobel_pkg.sv
// Shared types and constants for the sobel result path and its UART scheduler.
// Holds FSM encodings, the byte-slot helper and frame defaults.
package sobel_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      SEND = 2'd1,
      WAIT = 2'd2
   } tx_state_e;

   typedef enum logic [1:0] {
      ST_NONE = 2'd0,
      ST_HDR  = 2'd1,
      ST_SUM  = 2'd2
   } stat_e;

   localparam logic [7:0]  STATUS_HDR_DEF = 8'hA5;
   localparam int unsigned SRC_DIM        = 100;
   // a 3x3 kernel loses one pixel on every border
   localparam int unsigned FRAME_PIX_DEF  = (SRC_DIM - 2) * (SRC_DIM - 2);

   function automatic int unsigned byte_cyc(
      input int unsigned clk_freq,
      input int unsigned bps
   );
      return (clk_freq / bps) * 10;
   endfunction

endpackage

// File: rtl/uart_tx_sched_if.sv
// Pixel-in / UART-strobe-out bundle of uart_tx_sched.
// The master side feeds pixels; the slave side is the scheduler.
interface uart_tx_sched_if;

   logic       pix_flag;
   logic [7:0] pix_data;
   logic       tx_flag;
   logic [7:0] tx_data;
   logic       frame_done;
   logic       ovf;

   modport master (
      output pix_flag, pix_data,
      input  tx_flag, tx_data, frame_done, ovf
   );

   modport slave (
      input  pix_flag, pix_data,
      output tx_flag, tx_data, frame_done, ovf
   );

endinterface

// File: rtl/uart_tx_sched_sync_fifo.sv
// Synchronous FIFO with registered read data and same-edge push+pop.
// A push into a full FIFO is accepted only when a pop frees the slot.
module sync_fifo #(
   parameter int DEPTH = 16,
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             push,
   input  logic             pop,
   input  logic [WIDTH-1:0] wr_data,
   output logic [WIDTH-1:0] rd_data,
   output logic             full,
   output logic             empty
);

   localparam int AW = $clog2(DEPTH);

   logic [AW:0]      wr_ptr_q, wr_ptr_d;
   logic [AW:0]      rd_ptr_q, rd_ptr_d;
   logic [WIDTH-1:0] rd_data_q, rd_data_d;
   logic [WIDTH-1:0] mem_q [DEPTH];
   logic             do_push, do_pop;

   always_comb begin
      empty = (wr_ptr_q == rd_ptr_q);
      full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
              (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
      do_pop  = pop && !empty;
      do_push = push && (!full || do_pop);
      wr_ptr_d  = wr_ptr_q + {{AW{1'b0}}, do_push};
      rd_ptr_d  = rd_ptr_q + {{AW{1'b0}}, do_pop};
      rd_data_d = rd_data_q;
      if (do_pop) rd_data_d = mem_q[rd_ptr_q[AW-1:0]];
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q  <= '0;
         rd_ptr_q  <= '0;
         rd_data_q <= '0;
      end else begin
         wr_ptr_q  <= wr_ptr_d;
         rd_ptr_q  <= rd_ptr_d;
         rd_data_q <= rd_data_d;
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= wr_data;
   end

   assign rd_data = rd_data_q;

endmodule

// File: rtl/uart_tx_sched.sv
// Paces FIFO'd sobel result bytes onto uart_tx, one byte per frame slot.
// Define TX_SCHED_STATUS_EN to append an A5/checksum trailer to each frame.
module uart_tx_sched
   import sobel_pkg::*;
#(
   parameter int unsigned CLK_FREQ   = 50_000_000,
   parameter int unsigned UART_BPS   = 9600,
   parameter int unsigned FIFO_DEPTH = 16,
   parameter int unsigned FRAME_PIX  = FRAME_PIX_DEF,
   parameter logic [7:0]  STATUS_HDR = STATUS_HDR_DEF
) (
   input logic             sys_clk,
   input logic             sys_rst_n,
   uart_tx_sched_if.slave  bus
);

   localparam int unsigned BYTE_CYC = byte_cyc(CLK_FREQ, UART_BPS);
   localparam int SW = $clog2(BYTE_CYC);
   localparam int PW = $clog2(FRAME_PIX + 1);
   // slot_q reaches BYTE_CYC-1 on the edge that leaves WAIT
   localparam logic [SW-1:0] SLOT_END = SW'(BYTE_CYC - 2);
   localparam logic [PW-1:0] PIX_END  = PW'(FRAME_PIX - 1);

   tx_state_e     state_q, state_d;
   logic [SW-1:0] slot_q, slot_d;
   logic [PW-1:0] pix_q, pix_d;
   logic          tx_flag_q, tx_flag_d;
   logic [7:0]    tx_data_q, tx_data_d;
   logic          frame_done_q, frame_done_d;
   logic          ovf_q, ovf_d;
   logic          pop, pix_last;
   logic          fifo_full, fifo_empty;
   logic [7:0]    fifo_rd;
   logic          stat_pend, send_stat;

`ifdef TX_SCHED_STATUS_EN
   stat_e         stat_q, stat_d;
   logic          src_stat_q, src_stat_d;
   logic [7:0]    csum_q, csum_d;
   assign stat_pend = (stat_q != ST_NONE);
   assign send_stat = src_stat_q;
`else
   assign stat_pend = 1'b0;
   assign send_stat = 1'b0;
`endif

   assign pix_last = (pix_q == PIX_END);

   sync_fifo #(
      .DEPTH (FIFO_DEPTH),
      .WIDTH (8)
   ) u_fifo (
      .clk     (sys_clk),
      .rst_n   (sys_rst_n),
      .push    (bus.pix_flag),
      .pop     (pop),
      .wr_data (bus.pix_data),
      .rd_data (fifo_rd),
      .full    (fifo_full),
      .empty   (fifo_empty)
   );

   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         state_q      <= IDLE;
         slot_q       <= '0;
         pix_q        <= '0;
         tx_flag_q    <= 1'b0;
         tx_data_q    <= 8'h00;
         frame_done_q <= 1'b0;
         ovf_q        <= 1'b0;
`ifdef TX_SCHED_STATUS_EN
         stat_q       <= ST_NONE;
         src_stat_q   <= 1'b0;
         csum_q       <= 8'h00;
`endif
      end else begin
         state_q      <= state_d;
         slot_q       <= slot_d;
         pix_q        <= pix_d;
         tx_flag_q    <= tx_flag_d;
         tx_data_q    <= tx_data_d;
         frame_done_q <= frame_done_d;
         ovf_q        <= ovf_d;
`ifdef TX_SCHED_STATUS_EN
         stat_q       <= stat_d;
         src_stat_q   <= src_stat_d;
         csum_q       <= csum_d;
`endif
      end
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE: if (stat_pend || !fifo_empty) state_d = SEND;
         SEND: state_d = WAIT;
         WAIT: if (slot_q == SLOT_END) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      pop          = 1'b0;
      tx_flag_d    = 1'b0;
      tx_data_d    = tx_data_q;
      frame_done_d = 1'b0;
      slot_d       = slot_q;
      pix_d        = pix_q;
`ifdef TX_SCHED_STATUS_EN
      stat_d       = stat_q;
      src_stat_d   = src_stat_q;
      csum_d       = csum_q;
`endif
      unique case (state_q)
         IDLE: begin
            pop = !stat_pend && !fifo_empty;
`ifdef TX_SCHED_STATUS_EN
            src_stat_d = stat_pend;
`endif
         end
         SEND: begin
            tx_flag_d = 1'b1;
            slot_d    = '0;
            if (!send_stat) begin
               tx_data_d = fifo_rd;
               pix_d     = pix_last ? '0 : pix_q + 1'b1;
`ifdef TX_SCHED_STATUS_EN
               csum_d = csum_q ^ fifo_rd;
               if (pix_last) stat_d = ST_HDR;
`else
               frame_done_d = pix_last;
`endif
            end
`ifdef TX_SCHED_STATUS_EN
            else if (stat_q == ST_HDR) begin
               tx_data_d = STATUS_HDR;
               stat_d    = ST_SUM;
            end else begin
               tx_data_d    = csum_q;
               stat_d       = ST_NONE;
               csum_d       = 8'h00;
               frame_done_d = 1'b1;
            end
`endif
         end
         WAIT: slot_d = slot_q + 1'b1;
         default: ;
      endcase
      ovf_d = ovf_q | (bus.pix_flag & fifo_full & ~pop);
   end

   assign bus.tx_flag    = tx_flag_q;
   assign bus.tx_data    = tx_data_q;
   assign bus.frame_done = frame_done_q;
   assign bus.ovf        = ovf_q;

endmodule

// File: tb/tb_uart_tx_sched.sv
// Scoreboard bench for uart_tx_sched with a slot-level reference model.
// Honors TX_SCHED_STATUS_EN the same way the design does.
module tb_uart_tx_sched;

   localparam int unsigned CLK_FREQ   = 1000;
   localparam int unsigned UART_BPS   = 100;
   localparam int unsigned FIFO_DEPTH = 4;
   localparam int unsigned FRAME_PIX  = 4;
   localparam int unsigned BYTE_CYC   = 100;

   typedef struct {
      logic [7:0]  data;
      int unsigned cyc;
      logic        fd;
   } exp_t;

   logic sys_clk   = 1'b0;
   logic sys_rst_n = 1'b0;

   uart_tx_sched_if bus ();

   uart_tx_sched #(
      .CLK_FREQ   (CLK_FREQ),
      .UART_BPS   (UART_BPS),
      .FIFO_DEPTH (FIFO_DEPTH),
      .FRAME_PIX  (FRAME_PIX),
      .STATUS_HDR (8'hA5)
   ) dut (
      .sys_clk   (sys_clk),
      .sys_rst_n (sys_rst_n),
      .bus       (bus.slave)
   );

   always #5 sys_clk = ~sys_clk;

   int          vectors     = 0;
   int          miscompares = 0;
   int          n_strobe    = 0;
   int unsigned cyc         = 0;
   int unsigned next_pop    = 0;
   int unsigned last_strobe_cyc = 0;
   int          pix_m       = 0;
   logic [7:0]  csum_m      = 8'h00;
   logic        ovf_m       = 1'b0;
   logic [7:0]  last_tx_m   = 8'h00;
   logic [7:0]  b_m;
   logic        fd_m;
   exp_t        e_mon;

   logic [7:0]  q_m[$];
   logic [7:0]  stat_m[$];
   exp_t        sb[$];
   logic [7:0]  log_q[$];
   int unsigned strobe_cyc_q[$];
   int          fd_idx_q[$];

   // reference: one issue per slot, status first, drops when full
   always @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         q_m.delete();
         stat_m.delete();
         sb.delete();
         next_pop  = 0;
         pix_m     = 0;
         csum_m    = 8'h00;
         ovf_m     = 1'b0;
         last_tx_m = 8'h00;
      end else begin
         cyc++;
         if (cyc >= next_pop &&
             (stat_m.size() != 0 || q_m.size() != 0)) begin
            fd_m = 1'b0;
            if (stat_m.size() != 0) begin
               b_m  = stat_m.pop_front();
               fd_m = (stat_m.size() == 0);
            end else begin
               b_m = q_m.pop_front();
               csum_m ^= b_m;
               pix_m++;
               if (pix_m == int'(FRAME_PIX)) begin
                  pix_m = 0;
`ifdef TX_SCHED_STATUS_EN
                  stat_m.push_back(8'hA5);
                  stat_m.push_back(csum_m);
                  csum_m = 8'h00;
`else
                  fd_m = 1'b1;
`endif
               end
            end
            sb.push_back('{data: b_m, cyc: cyc + 1, fd: fd_m});
            next_pop = cyc + BYTE_CYC + 1;
         end
         if (bus.pix_flag === 1'b1) begin
            if (q_m.size() < FIFO_DEPTH) q_m.push_back(bus.pix_data);
            else ovf_m = 1'b1;
         end
      end
   end

   always @(negedge sys_clk) begin
      if (sys_rst_n) begin
         vectors++;
         if (bus.tx_flag === 1'b1) begin
            n_strobe++;
            log_q.push_back(bus.tx_data);
            strobe_cyc_q.push_back(cyc);
            last_strobe_cyc = cyc;
            if (bus.frame_done === 1'b1) fd_idx_q.push_back(log_q.size() - 1);
            if (sb.size() == 0) begin
               miscompares++;
               if (miscompares < 30)
                  $display("FAIL unexpected_strobe got data=%0h cyc=%0d exp none",
                           bus.tx_data, cyc);
            end else begin
               e_mon = sb.pop_front();
               last_tx_m = e_mon.data;
               if (bus.tx_data !== e_mon.data || bus.frame_done !== e_mon.fd ||
                   cyc != e_mon.cyc || bus.ovf !== ovf_m) begin
                  miscompares++;
                  if (miscompares < 30)
                     $display("FAIL strobe got d=%0h fd=%0b cyc=%0d ovf=%0b exp d=%0h fd=%0b cyc=%0d ovf=%0b",
                              bus.tx_data, bus.frame_done, cyc, bus.ovf,
                              e_mon.data, e_mon.fd, e_mon.cyc, ovf_m);
               end
            end
         end else if (bus.frame_done !== 1'b0 || bus.tx_data !== last_tx_m ||
                      bus.ovf !== ovf_m || bus.tx_flag !== 1'b0) begin
            miscompares++;
            if (miscompares < 30)
               $display("FAIL idle_cycle got fd=%0b d=%0h ovf=%0b exp fd=0 d=%0h ovf=%0b cyc=%0d",
                        bus.frame_done, bus.tx_data, bus.ovf, last_tx_m, ovf_m, cyc);
         end
      end
   end

   task automatic check(input string name, input logic [31:0] got,
                        input logic [31:0] exp);
      vectors++;
      if (got !== exp) begin
         miscompares++;
         $display("FAIL %s got=%0h exp=%0h", name, got, exp);
      end
   endtask

   task automatic check_seq(input string name, input logic [7:0] exp[$]);
      check({name, "_len"}, log_q.size(), exp.size());
      for (int i = 0; i < exp.size() && i < log_q.size(); i++)
         check(name, log_q[i], exp[i]);
   endtask

   task automatic clear_logs();
      log_q.delete();
      strobe_cyc_q.delete();
      fd_idx_q.delete();
   endtask

   task automatic drive(input logic [7:0] b);
      bus.pix_flag = 1'b1;
      bus.pix_data = b;
      @(negedge sys_clk);
      bus.pix_flag = 1'b0;
   endtask

   task automatic do_reset();
      @(negedge sys_clk);
      sys_rst_n = 1'b0;
      #1;
      check("rst_tx_flag", bus.tx_flag, 0);
      check("rst_tx_data", bus.tx_data, 0);
      check("rst_frame_done", bus.frame_done, 0);
      check("rst_ovf", bus.ovf, 0);
      repeat (3) @(negedge sys_clk);
      sys_rst_n = 1'b1;
      clear_logs();
   endtask

   task automatic drain(input int budget);
      int n = 0;
      while ((sb.size() != 0 || q_m.size() != 0 || stat_m.size() != 0) &&
             n < budget) begin
         @(negedge sys_clk);
         n++;
      end
      check("drain_timeout", n >= budget, 0);
      repeat (BYTE_CYC + 10) @(negedge sys_clk);
   endtask

   initial begin
      logic [7:0]  exp_q[$];
      int unsigned push_edge;
      int          n0;

      bus.pix_flag = 1'b0;
      bus.pix_data = 8'h00;

      // reset in the middle of a slot with bytes queued
      do_reset();
      for (int i = 0; i < 4; i++) drive(8'h11 * (i + 1));
      repeat (50) @(negedge sys_clk);
      do_reset();
      n0 = n_strobe;
      repeat (200) @(negedge sys_clk);
      check("t1_quiet", n_strobe - n0, 0);

      // single byte latency
      do_reset();
      push_edge = cyc + 1;
      drive(8'h3C);
      drain(400);
      exp_q = '{8'h3C};
      check_seq("t2_seq", exp_q);
      check("t2_latency", last_strobe_cyc - push_edge, 2);

      // four-byte burst pacing
      do_reset();
      exp_q = '{8'hC1, 8'h5A, 8'h7E, 8'h90};
      foreach (exp_q[i]) drive(exp_q[i]);
      drain(1000);
      check_seq("t3_seq", exp_q);
      for (int i = 1; i < strobe_cyc_q.size(); i++)
         check("t3_spacing", strobe_cyc_q[i] - strobe_cyc_q[i-1], BYTE_CYC + 1);
      check("t3_ovf", bus.ovf, 0);

      // one frame with trailer
      do_reset();
      exp_q = '{8'h01, 8'h02, 8'h04, 8'h08};
      foreach (exp_q[i]) drive(exp_q[i]);
      drain(1500);
`ifdef TX_SCHED_STATUS_EN
      exp_q = '{8'h01, 8'h02, 8'h04, 8'h08, 8'hA5, 8'h0F};
`endif
      check_seq("t4_seq", exp_q);
      check("t4_fd_count", fd_idx_q.size(), 1);
      if (fd_idx_q.size() == 1)
         check("t4_fd_pos", fd_idx_q[0], exp_q.size() - 1);

      // second frame pushed while the trailer is going out
      do_reset();
      exp_q = '{8'h01, 8'h02, 8'h04, 8'h08};
      foreach (exp_q[i]) drive(exp_q[i]);
      repeat (410) @(negedge sys_clk);
      drive(8'h10);
      drive(8'h20);
      drive(8'h40);
      drive(8'h80);
      drain(2500);
`ifdef TX_SCHED_STATUS_EN
      exp_q = '{8'h01, 8'h02, 8'h04, 8'h08, 8'hA5, 8'h0F,
                8'h10, 8'h20, 8'h40, 8'h80, 8'hA5, 8'hF0};
`else
      exp_q = '{8'h01, 8'h02, 8'h04, 8'h08,
                8'h10, 8'h20, 8'h40, 8'h80};
`endif
      check_seq("t5_seq", exp_q);
      check("t5_fd_count", fd_idx_q.size(), 2);
      check("t5_ovf", bus.ovf, 0);

      // overflow on the sixth back-to-back byte
      do_reset();
      for (int i = 0; i < 6; i++) drive(8'h61 + 8'(i));
      check("t6_ovf_set", bus.ovf, 1);
      drain(1500);
      check("t6_ovf_held", bus.ovf, 1);
      exp_q = '{8'h61, 8'h62, 8'h63, 8'h64, 8'h65};
      check_seq("t6_seq", exp_q);

      // random traffic against the model
      do_reset();
      for (int i = 0; i < 48; i++) begin
         drive(8'($urandom));
         repeat ($urandom_range(0, 180)) @(negedge sys_clk);
      end
      drain(6000);
      check("rand_ovf", bus.ovf, ovf_m);
      check("rand_sb_empty", sb.size(), 0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
